// File: rtl/bomb_drop_pkg.sv
// bomb_drop_pkg: shared defaults, slot-state encoding and slot count for the bomb dropper.
package bomb_drop_pkg;
    localparam int N_SLOTS       = 3;
    localparam int X_MAX_DEF     = 200;
    localparam int Y_GROUND_DEF  = 240;
    localparam int STEP_DEF      = 4;
    localparam int SPAWN_GAP_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FALL = 1'b1
    } slot_state_e;

    // Fold an out-of-range random column back into 0..x_max-1 with a single subtract.
    function automatic logic [7:0] wrap_x(input logic [7:0] r, input int x_max);
        return (int'(r) < x_max) ? r : 8'(int'(r) - x_max);
    endfunction
endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one falling-bomb slot -- state, column, row and landing detect.
module bomb_slot
    import bomb_drop_pkg::*;
#(
    parameter int Y_GROUND = Y_GROUND_DEF,
    parameter int STEP     = STEP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv_i,
    input  logic       spawn_i,
    input  logic [7:0] spawn_x_i,
    input  logic       hit_i,
    output logic       valid_o,
    output logic [7:0] x_o,
    output logic [7:0] y_o,
    output logic       land_o,
    output logic       pulse_o
);
    slot_state_e state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic        pulse_q;
    logic [8:0]  y_nxt;
    logic        lands;

    // A hit beats a landing in the same cycle, so the landing is suppressed outright.
    assign y_nxt = {1'b0, y_q} + 9'(STEP);
    assign lands = (state_q == FALL) && !hit_i && adv_i && (y_nxt >= 9'(Y_GROUND));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (state_q == FALL) begin
            if (hit_i || lands)
                state_d = IDLE;
            else if (adv_i)
                y_d = y_nxt[7:0];
        end else if (spawn_i) begin
            state_d = FALL;
            x_d     = spawn_x_i;
            y_d     = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pulse_q <= lands;
        end
    end

    assign valid_o = (state_q == FALL);
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign land_o  = lands;
    assign pulse_o = pulse_q;
endmodule

// File: rtl/bomb_drop_ctrl.sv
// bomb_drop_ctrl: spawn timer, slot arbitration and landing counter around three bomb slots.
module bomb_drop_ctrl
    import bomb_drop_pkg::*;
#(
    parameter int X_MAX     = X_MAX_DEF,
    parameter int Y_GROUND  = Y_GROUND_DEF,
    parameter int STEP      = STEP_DEF,
    parameter int SPAWN_GAP = SPAWN_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    input  logic [7:0] rand_num0,
    input  logic [7:0] rand_num1,
    input  logic [7:0] rand_num2,
    input  logic [2:0] hit,
    output logic [2:0] bomb_valid,
    output logic [7:0] bomb_x0,
    output logic [7:0] bomb_x1,
    output logic [7:0] bomb_x2,
    output logic [7:0] bomb_y0,
    output logic [7:0] bomb_y1,
    output logic [7:0] bomb_y2,
    output logic [2:0] ground_pulse,
    output logic       spawn_miss,
    output logic [7:0] ground_cnt
);
    logic       adv, attempt;
    logic [7:0] timer_q, timer_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] cnt_sum;
    logic       miss_q;
    logic [2:0] valid, spawn, land, pulse;
    logic [7:0] rand_a [N_SLOTS];
    logic [7:0] x_a [N_SLOTS];
    logic [7:0] y_a [N_SLOTS];

    assign adv     = tick && enable;
    assign attempt = adv && (timer_q == 8'(SPAWN_GAP - 1));
    assign timer_d = adv ? (attempt ? 8'd0 : timer_q + 8'd1) : timer_q;

    // Isolate the lowest clear bit of the registered valid mask; all-ones yields zero.
    assign spawn = attempt ? (~valid & (valid + 3'd1)) : 3'b000;

    assign cnt_sum = {1'b0, cnt_q} + 9'(land[0]) + 9'(land[1]) + 9'(land[2]);
    assign cnt_d   = (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];

    assign rand_a = '{rand_num0, rand_num1, rand_num2};

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        bomb_slot #(
            .Y_GROUND(Y_GROUND),
            .STEP    (STEP)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .adv_i    (adv),
            .spawn_i  (spawn[g]),
            .spawn_x_i(wrap_x(rand_a[g], X_MAX)),
            .hit_i    (hit[g]),
            .valid_o  (valid[g]),
            .x_o      (x_a[g]),
            .y_o      (y_a[g]),
            .land_o   (land[g]),
            .pulse_o  (pulse[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 8'd0;
            cnt_q   <= 8'd0;
            miss_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            miss_q  <= attempt && (&valid);
        end
    end

    assign bomb_valid   = valid;
    assign bomb_x0      = x_a[0];
    assign bomb_x1      = x_a[1];
    assign bomb_x2      = x_a[2];
    assign bomb_y0      = y_a[0];
    assign bomb_y1      = y_a[1];
    assign bomb_y2      = y_a[2];
    assign ground_pulse = pulse;
    assign spawn_miss   = miss_q;
    assign ground_cnt   = cnt_q;
endmodule

// File: tb/tb_bomb_drop_ctrl.sv
// tb_bomb_drop_ctrl: directed self-checking bench for bomb_drop_ctrl with default parameters.
module tb_bomb_drop_ctrl;
    logic       clk = 1'b0;
    logic       rst, enable, tick;
    logic [7:0] r0, r1, r2;
    logic [2:0] hit;
    logic [2:0] bomb_valid, ground_pulse;
    logic [7:0] bomb_x0, bomb_x1, bomb_x2, bomb_y0, bomb_y1, bomb_y2, ground_cnt;
    logic       spawn_miss;
    int         tests = 0;
    int         fails = 0;

    bomb_drop_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick        (tick),
        .rand_num0   (r0),
        .rand_num1   (r1),
        .rand_num2   (r2),
        .hit         (hit),
        .bomb_valid  (bomb_valid),
        .bomb_x0     (bomb_x0),
        .bomb_x1     (bomb_x1),
        .bomb_x2     (bomb_x2),
        .bomb_y0     (bomb_y0),
        .bomb_y1     (bomb_y1),
        .bomb_y2     (bomb_y2),
        .ground_pulse(ground_pulse),
        .spawn_miss  (spawn_miss),
        .ground_cnt  (ground_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each tick is high across one rising edge, followed by an idle cycle.
    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic tick_hit(input logic [2:0] h);
        @(negedge clk);
        tick = 1'b1;
        hit  = h;
        @(negedge clk);
        tick = 1'b0;
        hit  = 3'b000;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; tick = 1'b0; hit = 3'b000;
        r0 = 8'd250; r1 = 8'd0; r2 = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", bomb_valid, 0);
        chk("rst_cnt", ground_cnt, 0);
        chk("rst_pulse", ground_pulse, 0);
        chk("rst_miss", spawn_miss, 0);
        chk("rst_x0", bomb_x0, 0);
        chk("rst_y0", bomb_y0, 0);

        enable = 1'b1;
        ticks(15);
        chk("no_early_spawn", bomb_valid, 0);
        ticks(1);
        chk("spawn_valid", bomb_valid, 3'b001);
        chk("spawn_x0_wrap", bomb_x0, 50);
        chk("spawn_y0", bomb_y0, 0);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        r0 = 8'd10; r1 = 8'd120; r2 = 8'd255;
        ticks(16);
        chk("x0_direct", bomb_x0, 10);
        ticks(1);
        chk("y0_first_step", bomb_y0, 4);
        ticks(47);
        chk("miss_pulse", spawn_miss, 1);
        chk("miss_valid", bomb_valid, 3'b111);
        chk("miss_y0", bomb_y0, 192);
        chk("miss_y1", bomb_y1, 128);
        chk("miss_y2", bomb_y2, 64);
        chk("miss_x1", bomb_x1, 120);
        chk("miss_x2", bomb_x2, 55);
        @(negedge clk);
        chk("miss_one_cycle", spawn_miss, 0);
        ticks(11);
        chk("y0_236", bomb_y0, 236);
        chk("pre_land_valid", bomb_valid, 3'b111);
        ticks(1);
        chk("land_valid", bomb_valid, 3'b110);
        chk("land_pulse", ground_pulse, 3'b001);
        chk("land_cnt", ground_cnt, 1);
        @(negedge clk);
        chk("land_pulse_clear", ground_pulse, 0);

        ticks(15);
        chk("y1_236", bomb_y1, 236);
        chk("respawn_valid", bomb_valid, 3'b111);
        tick_hit(3'b010);
        chk("hit_land_valid", bomb_valid, 3'b101);
        chk("hit_land_pulse", ground_pulse, 0);
        chk("hit_land_cnt", ground_cnt, 1);
        chk("hit_y0", bomb_y0, 48);
        chk("hit_y2", bomb_y2, 176);

        enable = 1'b0;
        ticks(40);
        chk("frz_valid", bomb_valid, 3'b101);
        chk("frz_x0", bomb_x0, 10);
        chk("frz_y0", bomb_y0, 48);
        chk("frz_y2", bomb_y2, 176);
        @(negedge clk) hit = 3'b001;
        @(negedge clk) hit = 3'b000;
        chk("frz_hit0", bomb_valid, 3'b100);
        enable = 1'b1;
        r0 = 8'd77;
        ticks(3);
        chk("timer_held_nospawn", bomb_valid, 3'b100);
        chk("resume_y2", bomb_y2, 188);
        ticks(1);
        chk("timer_held_spawn", bomb_valid, 3'b101);
        chk("respawn_x0", bomb_x0, 77);
        chk("respawn_y0", bomb_y0, 0);
        chk("resume_y2b", bomb_y2, 192);

        @(negedge clk);
        rst = 1'b1; tick = 1'b1; hit = 3'b111;
        @(negedge clk);
        rst = 1'b0; tick = 1'b0; hit = 3'b000;
        chk("midrst_valid", bomb_valid, 0);
        chk("midrst_cnt", ground_cnt, 0);
        chk("midrst_pulse", ground_pulse, 0);
        chk("midrst_miss", spawn_miss, 0);
        chk("midrst_y2", bomb_y2, 0);
        chk("midrst_x0", bomb_x0, 0);

        @(negedge clk) tick = 1'b1;
        repeat (7000) @(negedge clk);
        tick = 1'b0;
        chk("cnt_saturate", ground_cnt, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bomb_drop_ctrl.md
BOMB_DROP_CTRL -- requirements
Module: bomb_drop_ctrl

Interface
REQ-001 The block SHALL have parameter X_MAX, default 200, meaning the exclusive upper bound of a bomb column.
REQ-002 The block SHALL have parameter Y_GROUND, default 240, meaning the row at which a falling bomb lands.
REQ-003 The block SHALL have parameter STEP, default 4, meaning the rows advanced per tick.
REQ-004 The block SHALL have parameter SPAWN_GAP, default 16, meaning the ticks between spawn attempts (legal range 1..255).
REQ-005 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  game running; low freezes motion and spawning
- tick  in  1  one-cycle frame strobe
- rand_num0, rand_num1, rand_num2  in  8 each  random column sources, one per slot
- hit  in  3  per-slot clear request (player hit / bomb defused)
- bomb_valid  out  3  slot active
- bomb_x0, bomb_x1, bomb_x2  out  8 each  slot column
- bomb_y0, bomb_y1, bomb_y2  out  8 each  slot row
- ground_pulse  out  3  one-cycle landing strobe per slot
- spawn_miss  out  1  one-cycle strobe: spawn attempt found no idle slot
- ground_cnt  out  8  saturating count of landed bombs

Function
REQ-006 Each slot SHALL be in one of two states, IDLE or FALL; bomb_valid[i] SHALL be 1 exactly in FALL.
REQ-007 A spawn timer SHALL advance by 1 on each cycle with tick=1 and enable=1; on the tick where it equals SPAWN_GAP-1 it SHALL reload 0 and issue a spawn attempt.
REQ-008 A spawn attempt SHALL select the lowest-index slot that is IDLE in the current registered state; that slot SHALL enter FALL on the next edge with y=0 and x=rand_num_i if rand_num_i<X_MAX, else x=rand_num_i-X_MAX.
REQ-009 If no slot is IDLE at a spawn attempt, spawn_miss SHALL pulse for one cycle, no slot SHALL change, and the timer SHALL still reload 0.
REQ-010 On each tick with enable=1, every FALL slot not spawning that cycle SHALL update y to y+STEP, computed in 9 bits.
REQ-011 If the 9-bit y+STEP >= Y_GROUND, the slot SHALL instead go IDLE, assert ground_pulse[i] for exactly one cycle, and increment ground_cnt, saturating at 255.
REQ-012 hit[i]=1 on a FALL slot SHALL force IDLE on the next edge regardless of enable and tick; it SHALL take priority over movement and landing, with no ground_pulse and no count.
REQ-013 hit[i]=1 on an IDLE slot SHALL be ignored; a slot freed by hit SHALL not be eligible for spawn until the following cycle.
REQ-014 Landings on multiple slots in the same cycle SHALL each pulse ground_pulse; ground_cnt SHALL add the number of landings, saturating at 255.
REQ-015 With enable=0, the timer, x and y SHALL hold; only hit and rst SHALL change state.
REQ-016 In IDLE, x and y SHALL hold their last values; consumers SHALL qualify them with bomb_valid.
REQ-017 All outputs SHALL be registered; a tick produces its effect visible one cycle after the tick edge.

Reset
REQ-018 On rst=1 at a clk edge the block SHALL set all slots IDLE, all x and y to 0, the timer to 0, ground_cnt to 0, and ground_pulse and spawn_miss to 0; rst SHALL override hit, tick and enable.
REQ-019 Reset mid-fall SHALL discard in-flight bombs without asserting ground_pulse.

Structure
REQ-020 A shared package SHALL hold the parameter defaults, the slot-state encoding (IDLE=0, FALL=1) and the slot count constant (3).
REQ-021 Per-slot logic (state, x, y, landing detect) SHALL be one sub-module, bomb_slot, instantiated three times; spawn arbitration, timer and counter SHALL stay in the top.

Verification
REQ-022 Scenario: rst, then enable=1, rand_num0=250, 16 ticks -> slot0 valid, x0=50, y0=0 one cycle after the 16th tick.
REQ-023 Scenario: rand_num0=10, then 60 more ticks -> y0 steps 4,8,...,236; on the 60th tick slot0 goes IDLE, ground_pulse[0] pulses once, ground_cnt=1.
REQ-024 Scenario: all three slots FALL, next spawn attempt -> spawn_miss pulses once and no slot changes.
REQ-025 Scenario: hit[1] in the same cycle slot1 would land -> slot1 IDLE, no ground_pulse[1], ground_cnt unchanged.
REQ-026 Scenario: enable=0 for 40 ticks mid-fall -> x, y and the timer are unchanged; hit[0] still clears slot0.
REQ-027 Scenario: rst asserted with 2 slots falling -> next cycle bomb_valid=000, ground_cnt=0, no pulses.
